contador_multimodo: RTL

Parametrised successor to the team's fixed 4-bit reversible LED counter. It adds a prescaler, a selectable counting code (binary, Johnson, ring, Gray), synchronous load, enable, and tick/wrap status pulses. It drives board LEDs directly or feeds downstream display logic, and replaces the fixed counter instance under the top-level board module.

---
 rtl/contador_multimodo_pkg.sv | 16 +
 rtl/divisor_tick.sv | 39 +++
 rtl/contador_multimodo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/contador_multimodo_pkg.sv
// Shared definitions for the multimode counter and its prescaler.
package contador_multimodo_pkg;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_RING    = 2'b10,
    MODE_GRAY    = 2'b11
  } mode_e;

  // Prescaler counter width for a given ratio, never below one bit.
  function automatic int unsigned div_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: emits a one-cycle step every DIV enabled clock cycles.
module divisor_tick
  import contador_multimodo_pkg::*;
#(
  parameter int unsigned DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned DIV_W = div_w(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/contador_multimodo.sv
// Reversible multimode counter (binary, Johnson, ring, Gray) with prescaler,
// synchronous load and tick/wrap status pulses.
module contador_multimodo
  import contador_multimodo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rev,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic is_onehot(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - ONE)) == '0);
  endfunction

  // Johnson codes are a run of ones anchored at the LSB, or its complement.
  function automatic logic is_johnson(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] nx;
    nx = ~x;
    return ((x & (x + ONE)) == '0) || ((nx & (nx + ONE)) == '0);
  endfunction

  mode_e            mode_q, mode_d, mode_in;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic             mode_chg, step;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);

  divisor_tick #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (mode_chg | load),
    .step (step)
  );

  always_comb begin
    mode_d = mode_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (mode_chg) begin
      mode_d = mode_in;
      cnt_d  = '0;
      out_d  = (mode_in == MODE_RING) ? ONE : '0;
    end else if (load) begin
      case (mode_q)
        MODE_BIN:     out_d = load_val;
        MODE_GRAY: begin
          cnt_d = load_val;
          out_d = gray(load_val);
        end
        MODE_RING:    out_d = is_onehot(load_val) ? load_val : ONE;
        MODE_JOHNSON: out_d = is_johnson(load_val) ? load_val : '0;
        default:      out_d = out_q;
      endcase
    end else if (step) begin
      tick_d = 1'b1;
      case (mode_q)
        MODE_BIN: begin
          out_d  = rev ? out_q - ONE : out_q + ONE;
          wrap_d = rev ? (out_q == '0) : (out_q == '1);
        end
        MODE_GRAY: begin
          cnt_d  = rev ? cnt_q - ONE : cnt_q + ONE;
          out_d  = gray(cnt_d);
          wrap_d = rev ? (cnt_q == '0) : (cnt_q == '1);
        end
        MODE_JOHNSON: begin
          if (!is_johnson(out_q)) begin
            out_d = '0;
          end else begin
            out_d  = rev ? {~out_q[0], out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            wrap_d = rev ? (out_q == '0) : (out_q == MSB_ONLY);
          end
        end
        MODE_RING: begin
          if (!is_onehot(out_q)) begin
            out_d = ONE;
          end else begin
            out_d  = rev ? {out_q[0], out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            wrap_d = rev ? (out_q == ONE) : (out_q == MSB_ONLY);
          end
        end
        default: out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_BIN;
      out_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
